// File: rtl/multiboot_sched_if.sv
// Request/status bundle between the core's I/O decode and the multiboot
// scheduler.
//   CPU_WR    1-cycle write strobe of the control port
//   CPU_DATA  write data (unlock byte or slot number)
//   KBD_REQ   synchronised hotkey level
//   WDOG_REQ  1-cycle watchdog timeout pulse
//   spi_addr  SPI address of the latched bitstream slot
//   REBOOT    reboot request towards the ICAP sequencer
//   BUSY      launch sequence in progress
//   SLOT      currently latched slot
//   ERR       sticky reconfiguration-timeout flag
// master drives the requests and reads the status; slave is the scheduler.
interface multiboot_sched_if;
  logic        CPU_WR;
  logic [7:0]  CPU_DATA;
  logic        KBD_REQ;
  logic        WDOG_REQ;
  logic [23:0] spi_addr;
  logic        REBOOT;
  logic        BUSY;
  logic [1:0]  SLOT;
  logic        ERR;

  modport master (
    output CPU_WR, CPU_DATA, KBD_REQ, WDOG_REQ,
    input  spi_addr, REBOOT, BUSY, SLOT, ERR
  );

  modport slave (
    input  CPU_WR, CPU_DATA, KBD_REQ, WDOG_REQ,
    output spi_addr, REBOOT, BUSY, SLOT, ERR
  );
endinterface

// File: rtl/multiboot_sched.sv
// Reboot request scheduler in front of the multiboot ICAP sequencer.
// Arbitrates CPU (unlock + slot write), keyboard hotkey (long press) and
// watchdog requests, latches the target slot, presents its SPI address for
// a setup window, pulses REBOOT and then waits a guard time. If the FPGA is
// still running when the guard time ends, ERR is raised.
// Ports:
//   CLK          system/ICAP clock
//   MBT_RESET_N  asynchronous active-low reset
//   bus          multiboot_sched_if.slave (requests in, spi_addr/REBOOT/
//                BUSY/SLOT/ERR out, all registered)
// SETUP_CYC, PULSE_CYC, GUARD_CYC, UNLOCK_TMO and KBD_HOLD must be >= 1.
module multiboot_sched #(
  parameter logic [23:0] SLOT_BASE   = 24'h058000,
  parameter logic [23:0] SLOT_STRIDE = 24'h040000,
  parameter logic [7:0]  UNLOCK_KEY  = 8'hA5,
  parameter int          UNLOCK_TMO  = 1024,
  parameter int          KBD_HOLD    = 65536,
  parameter int          SETUP_CYC   = 8,
  parameter int          PULSE_CYC   = 4,
  parameter int          GUARD_CYC   = 4096
) (
  input logic               CLK,
  input logic               MBT_RESET_N,
  multiboot_sched_if.slave  bus
);

  // One shared counter serves the unlock timeout and the three launch phases.
  localparam int MAX_A   = (UNLOCK_TMO > GUARD_CYC) ? UNLOCK_TMO : GUARD_CYC;
  localparam int MAX_B   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int KCNT_W  = $clog2(KBD_HOLD + 1);

  typedef enum logic [2:0] {
    IDLE,
    UNLOCKED,
    LAUNCH,
    PULSE,
    GUARD
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [KCNT_W-1:0] kcnt;
  logic [1:0]        slot_q;
  logic [23:0]       addr_q;
  logic              reboot_q;
  logic              busy_q;
  logic              err_q;

  logic              kbd_hit;
  logic              go;
  logic [1:0]        go_slot;

  // Slot address, wrapping modulo 2^24.
  function automatic logic [23:0] addr_of(input logic [1:0] s);
    return SLOT_BASE + SLOT_STRIDE * {22'd0, s};
  endfunction

  // Press-length counter: clears on release, saturates at KBD_HOLD so a
  // held key produces exactly one request.
  function automatic logic [KCNT_W-1:0] kbd_next(input logic lvl,
                                                 input logic [KCNT_W-1:0] c);
    if (!lvl)
      return '0;
    if (c == KCNT_W'(KBD_HOLD))
      return c;
    return c + KCNT_W'(1);
  endfunction

  // The press reaches KBD_HOLD in this cycle.
  assign kbd_hit = bus.KBD_REQ && (kcnt == KCNT_W'(KBD_HOLD - 1));

  // Arbitration: watchdog and keyboard (both slot 0) beat a CPU slot write.
  always_comb begin
    go      = 1'b0;
    go_slot = 2'd0;
    if (state == IDLE || state == UNLOCKED) begin
      if (bus.WDOG_REQ || kbd_hit) begin
        go = 1'b1;
      end else if (state == UNLOCKED && bus.CPU_WR &&
                   bus.CPU_DATA[7:2] == 6'd0) begin
        go      = 1'b1;
        go_slot = bus.CPU_DATA[1:0];
      end
    end
  end

  always_ff @(posedge CLK or negedge MBT_RESET_N) begin
    if (!MBT_RESET_N) begin
      state    <= IDLE;
      cnt      <= '0;
      kcnt     <= '0;
      slot_q   <= 2'd0;
      addr_q   <= SLOT_BASE;
      reboot_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      kcnt <= kbd_next(bus.KBD_REQ, kcnt);
      if (go) begin
        state  <= LAUNCH;
        cnt    <= '0;
        slot_q <= go_slot;
        addr_q <= addr_of(go_slot);
        busy_q <= 1'b1;
        err_q  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.CPU_WR && bus.CPU_DATA == UNLOCK_KEY) begin
              state <= UNLOCKED;
              cnt   <= '0;
            end
          end
          UNLOCKED: begin
            // A write reaching here had a non-zero upper field: rejected.
            if (bus.CPU_WR) begin
              state <= IDLE;
            end else if (cnt == CNT_W'(UNLOCK_TMO - 1)) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          LAUNCH: begin
            if (cnt == CNT_W'(SETUP_CYC - 1)) begin
              state    <= PULSE;
              cnt      <= '0;
              reboot_q <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          PULSE: begin
            if (cnt == CNT_W'(PULSE_CYC - 1)) begin
              state    <= GUARD;
              cnt      <= '0;
              reboot_q <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          GUARD: begin
            // Still alive after the guard time: reconfiguration failed.
            if (cnt == CNT_W'(GUARD_CYC - 1)) begin
              state  <= IDLE;
              cnt    <= '0;
              busy_q <= 1'b0;
              err_q  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.spi_addr = addr_q;
  assign bus.REBOOT   = reboot_q;
  assign bus.BUSY     = busy_q;
  assign bus.SLOT     = slot_q;
  assign bus.ERR      = err_q;

endmodule

// File: tb/tb_multiboot_sched.sv
// Bench for multiboot_sched. Two instances share one stimulus: dut_a uses
// the default slot stride, dut_b a stride of 24'h400000. KBD_HOLD is
// shortened to keep the simulation short; all other timing is default.
module tb_multiboot_sched;
  localparam logic [23:0] BASE  = 24'h058000;
  localparam logic [23:0] STR_A = 24'h040000;
  localparam logic [23:0] STR_B = 24'h400000;
  localparam int KEY   = 8'hA5;
  localparam int TMO   = 1024;
  localparam int KH    = 200;
  localparam int S     = 8;
  localparam int P     = 4;
  localparam int G     = 4096;
  localparam int TOTAL = S + P + G;

  logic       clk;
  logic       rst_n;
  logic       cpu_wr;
  logic [7:0] cpu_data;
  logic       kbd;
  logic       wdog;

  multiboot_sched_if ifa ();
  multiboot_sched_if ifb ();

  assign ifa.CPU_WR   = cpu_wr;
  assign ifa.CPU_DATA = cpu_data;
  assign ifa.KBD_REQ  = kbd;
  assign ifa.WDOG_REQ = wdog;
  assign ifb.CPU_WR   = cpu_wr;
  assign ifb.CPU_DATA = cpu_data;
  assign ifb.KBD_REQ  = kbd;
  assign ifb.WDOG_REQ = wdog;

  multiboot_sched #(.SLOT_STRIDE(STR_A), .KBD_HOLD(KH)) dut_a (
    .CLK(clk), .MBT_RESET_N(rst_n), .bus(ifa));
  multiboot_sched #(.SLOT_STRIDE(STR_B), .KBD_HOLD(KH)) dut_b (
    .CLK(clk), .MBT_RESET_N(rst_n), .bus(ifb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int n_launch = 0;

  // Timeline model: a launch starting in cycle l_t keeps BUSY for TOTAL
  // cycles with REBOOT in [l_t+S, l_t+S+P); an unlock in cycle u_t opens a
  // slot-write window over cycles u_t+1 .. u_t+TMO.
  int       mcyc = 0;
  bit       launched = 0;
  int       l_t = 0;
  bit       unlocked = 0;
  int       u_t = 0;
  int       krun = 0;
  bit [1:0] m_slot = 0;
  bit       m_err = 0;

  task automatic m_launch(input bit [1:0] s, input int c);
    launched = 1;
    l_t      = c + 1;
    m_slot   = s;
    m_err    = 0;
    unlocked = 0;
  endtask

  task automatic m_step();
    int c;
    bit busy_c, unl_c, hit;
    if (!rst_n) begin
      launched = 0; unlocked = 0; krun = 0; m_slot = 0; m_err = 0;
    end else begin
      c      = mcyc;
      busy_c = launched && c >= l_t && c < l_t + TOTAL;
      unl_c  = unlocked && (c - u_t) >= 1 && (c - u_t) <= TMO;
      krun   = kbd ? krun + 1 : 0;
      hit    = kbd && krun == KH;
      if (!busy_c) begin
        if (wdog || hit) begin
          m_launch(2'd0, c);
        end else if (cpu_wr) begin
          if (unl_c) begin
            unlocked = 0;
            if (cpu_data[7:2] == 6'd0) m_launch(cpu_data[1:0], c);
          end else if (cpu_data == KEY) begin
            unlocked = 1;
            u_t      = c;
          end
        end
      end
      if (launched && c + 1 == l_t + TOTAL) m_err = 1;
    end
    mcyc++;
  endtask

  initial forever begin
    @(posedge clk);
    m_step();
  end

  // Every-cycle comparison of both instances against the model.
  bit prev_busy = 0;
  initial forever begin
    logic [23:0] ea, eb;
    logic        eb_busy, e_reb, e_err;
    logic [1:0]  e_slot;
    @(negedge clk);
    if (!rst_n) begin
      ea = BASE; eb = BASE; eb_busy = 0; e_reb = 0; e_err = 0; e_slot = 0;
    end else begin
      eb_busy = launched && mcyc >= l_t && mcyc < l_t + TOTAL;
      e_reb   = launched && mcyc >= l_t + S && mcyc < l_t + S + P;
      e_err   = m_err;
      e_slot  = m_slot;
      ea      = BASE + STR_A * {22'd0, m_slot};
      eb      = BASE + STR_B * {22'd0, m_slot};
    end
    n_cmp++;
    if (ifa.BUSY !== eb_busy || ifa.REBOOT !== e_reb || ifa.ERR !== e_err ||
        ifa.SLOT !== e_slot || ifa.spi_addr !== ea || ifb.spi_addr !== eb ||
        ifb.BUSY !== eb_busy || ifb.REBOOT !== e_reb || ifb.ERR !== e_err ||
        ifb.SLOT !== e_slot) begin
      n_bad++;
      $display("FAIL model t=%0t got busy=%b reb=%b err=%b slot=%0d addr_a=%h addr_b=%h want busy=%b reb=%b err=%b slot=%0d addr_a=%h addr_b=%h",
               $time, ifa.BUSY, ifa.REBOOT, ifa.ERR, ifa.SLOT, ifa.spi_addr,
               ifb.spi_addr, eb_busy, e_reb, e_err, e_slot, ea, eb);
    end
    if (ifa.BUSY && !prev_busy) n_launch++;
    prev_busy = ifa.BUSY;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    cpu_wr   = 1'b1;
    cpu_data = d;
    tick();
    cpu_wr   = 1'b0;
    cpu_data = 8'h00;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (ifa.BUSY && n < 6000) begin
      tick();
      n++;
    end
    chk(nm, {31'd0, ifa.BUSY}, 32'd0);
  endtask

  initial begin
    int l0;
    rst_n = 1'b0; cpu_wr = 1'b0; cpu_data = 8'h00; kbd = 1'b0; wdog = 1'b0;
    repeat (3) tick();
    chk("rst_addr", {8'd0, ifa.spi_addr}, 32'h058000);
    chk("rst_slot", {30'd0, ifa.SLOT}, 32'd0);
    chk("rst_busy", {31'd0, ifa.BUSY}, 32'd0);
    chk("rst_err",  {31'd0, ifa.ERR}, 32'd0);
    rst_n = 1'b1;
    tick();

    // CPU launch of slot 2, full sequence through guard expiry.
    wr(8'hA5);
    wr(8'h02);
    chk("t1_slot",   {30'd0, ifa.SLOT}, 32'd2);
    chk("t1_addr_a", {8'd0, ifa.spi_addr}, 32'h0D8000);
    chk("t1_addr_b", {8'd0, ifb.spi_addr}, 32'h858000);
    chk("t1_busy",   {31'd0, ifa.BUSY}, 32'd1);
    repeat (7) tick();
    chk("t1_reb_c8", {31'd0, ifa.REBOOT}, 32'd0);
    tick();
    chk("t1_reb_c9", {31'd0, ifa.REBOOT}, 32'd1);
    repeat (3) tick();
    chk("t1_reb_c12", {31'd0, ifa.REBOOT}, 32'd1);
    tick();
    chk("t1_reb_c13", {31'd0, ifa.REBOOT}, 32'd0);
    chk("t1_busy_guard", {31'd0, ifa.BUSY}, 32'd1);
    repeat (G - 1) tick();
    chk("t1_busy_end", {31'd0, ifa.BUSY}, 32'd1);
    chk("t1_err_end",  {31'd0, ifa.ERR}, 32'd0);
    tick();
    chk("t6_busy", {31'd0, ifa.BUSY}, 32'd0);
    chk("t6_err",  {31'd1 & 31'd0, ifa.ERR}, 32'd1);

    // Slot write on the last cycle of the unlock window is accepted.
    wr(8'hA5);
    repeat (TMO - 1) tick();
    wr(8'h03);
    chk("tmo_edge_busy", {31'd0, ifa.BUSY}, 32'd1);
    chk("tmo_edge_err",  {31'd0, ifa.ERR}, 32'd0);
    chk("t3_addr_a", {8'd0, ifa.spi_addr}, 32'h118000);
    chk("t3_addr_b", {8'd0, ifb.spi_addr}, 32'hC58000);
    wait_idle("tmo_edge_idle");

    // One cycle later the window has closed.
    wr(8'hA5);
    repeat (TMO) tick();
    wr(8'h01);
    repeat (3) tick();
    chk("t2_busy", {31'd0, ifa.BUSY}, 32'd0);
    chk("t2_slot", {30'd0, ifa.SLOT}, 32'd3);

    // Watchdog beats a simultaneous CPU slot write.
    wr(8'hA5);
    cpu_wr = 1'b1; cpu_data = 8'h03; wdog = 1'b1;
    tick();
    cpu_wr = 1'b0; cpu_data = 8'h00; wdog = 1'b0;
    chk("t4_slot", {30'd0, ifa.SLOT}, 32'd0);
    chk("t4_addr", {8'd0, ifa.spi_addr}, 32'h058000);
    chk("t4_busy", {31'd0, ifa.BUSY}, 32'd1);
    wait_idle("t4_idle");

    // Rejected slot byte drops back to IDLE; a later plain 03 is ignored.
    wr(8'hA5);
    wr(8'h41);
    repeat (2) tick();
    chk("t3_rej_busy", {31'd0, ifa.BUSY}, 32'd0);
    wr(8'h03);
    repeat (2) tick();
    chk("t3_idle_busy", {31'd0, ifa.BUSY}, 32'd0);
    wr(8'hA5);
    wr(8'h03);
    chk("t3_slot",    {30'd0, ifa.SLOT}, 32'd3);
    chk("t3_addr_b2", {8'd0, ifb.spi_addr}, 32'hC58000);
    wait_idle("t3_idle");

    // Keyboard: one cycle short, then an exact hold held through guard.
    kbd = 1'b1;
    repeat (KH - 1) tick();
    kbd = 1'b0;
    repeat (4) tick();
    chk("t5_short", {31'd0, ifa.BUSY}, 32'd0);
    l0 = n_launch;
    kbd = 1'b1;
    repeat (KH) tick();
    chk("t5_busy", {31'd0, ifa.BUSY}, 32'd1);
    chk("t5_slot", {30'd0, ifa.SLOT}, 32'd0);
    repeat (20) tick();
    wdog = 1'b1;
    tick();
    wdog = 1'b0;
    wait_idle("t5_idle");
    repeat (50) tick();
    chk("t5_one_launch", n_launch - l0, 32'd1);
    kbd = 1'b0;
    tick();

    // Reset during the pulse.
    wr(8'hA5);
    wr(8'h02);
    repeat (9) tick();
    chk("t6_reb_pre", {31'd0, ifa.REBOOT}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_reb",  {31'd0, ifa.REBOOT}, 32'd0);
    chk("t6_rbusy", {31'd0, ifa.BUSY}, 32'd0);
    chk("t6_rslot", {30'd0, ifa.SLOT}, 32'd0);
    chk("t6_raddr", {8'd0, ifb.spi_addr}, 32'h058000);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    wr(8'hA5);
    wr(8'h01);
    chk("post_rst_addr", {8'd0, ifa.spi_addr}, 32'h098000);
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
